// File: rtl/pair_link_monitor.sv
// Four-pair link pulse qualifier: synchronizes each pair line and tracks DOWN/ACQUIRE/UP per pair.
// Reports per-pair and aggregate link status, a change strobe and a saturating drop counter.
module pair_link_monitor #(
    parameter int MinGap     = 40,
    parameter int MaxGap     = 120,
    parameter int MaxWidth   = 8,
    parameter int PulsesToUp = 3
) (
    input  logic       Clock100Mhz,
    input  logic       Reset,
    input  logic       TIA_568B12,
    input  logic       TIA_568B36,
    input  logic       TIA_568B54,
    input  logic       TIA_568B78,
    output logic [3:0] LinkUp,
    output logic [2:0] PairsUp,
    output logic       AllUp,
    output logic       LinkChange,
    output logic [7:0] DropCount
);

    localparam int GapW   = $clog2(MaxGap + 2);
    localparam int WidthW = $clog2(MaxWidth + 2);

    localparam logic [GapW-1:0]   GapMin    = GapW'(MinGap);
    localparam logic [GapW-1:0]   GapMax    = GapW'(MaxGap);
    localparam logic [GapW-1:0]   GapSat    = GapW'(MaxGap + 1);
    localparam logic [WidthW-1:0] WidthSat  = WidthW'(MaxWidth + 1);
    localparam logic [3:0]        GoodLimit = 4'(PulsesToUp);

    typedef enum logic [1:0] {
        ST_DOWN    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_UP      = 2'd2
    } state_t;

    logic [3:0] pair_in;
    logic [3:0] up_vec;
    logic [3:0] leave_up;

    assign pair_in = {TIA_568B78, TIA_568B54, TIA_568B36, TIA_568B12};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pair
            logic              sync1_q, sync2_q, prev_q;
            logic              edge_det, gap_ok;
            logic [GapW-1:0]   gap_q, gap_d;
            logic [WidthW-1:0] wid_q, wid_d;
            logic [3:0]        good_q, good_d;
            state_t            state_q, state_d;

            always_comb begin
                edge_det = sync2_q & ~prev_q;
                gap_ok   = (gap_q >= GapMin) && (gap_q <= GapMax);

                if (edge_det)
                    gap_d = '0;
                else if (gap_q == GapSat)
                    gap_d = gap_q;
                else
                    gap_d = gap_q + GapW'(1);

                if (!sync2_q)
                    wid_d = '0;
                else if (wid_q == WidthSat)
                    wid_d = wid_q;
                else
                    wid_d = wid_q + WidthW'(1);

                // Priority: width fault, then timeout, then edge qualification.
                state_d = state_q;
                good_d  = good_q;
                if (wid_q == WidthSat) begin
                    state_d = ST_DOWN;
                end else if (state_q != ST_DOWN && gap_q == GapMax && !edge_det) begin
                    state_d = ST_DOWN;
                end else if (edge_det) begin
                    case (state_q)
                        ST_DOWN: begin
                            state_d = ST_ACQUIRE;
                            good_d  = '0;
                        end
                        ST_ACQUIRE: begin
                            if (gap_ok) begin
                                good_d = good_q + 4'd1;
                                if (good_d == GoodLimit)
                                    state_d = ST_UP;
                            end else begin
                                state_d = ST_DOWN;
                            end
                        end
                        ST_UP: begin
                            if (!gap_ok)
                                state_d = ST_DOWN;
                        end
                        default: state_d = ST_DOWN;
                    endcase
                end
            end

            always_ff @(posedge Clock100Mhz) begin
                if (Reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    prev_q  <= 1'b0;
                    gap_q   <= '0;
                    wid_q   <= '0;
                    good_q  <= '0;
                    state_q <= ST_DOWN;
                end else begin
                    sync1_q <= pair_in[gi];
                    sync2_q <= sync1_q;
                    prev_q  <= sync2_q;
                    gap_q   <= gap_d;
                    wid_q   <= wid_d;
                    good_q  <= good_d;
                    state_q <= state_d;
                end
            end

            assign up_vec[gi]   = (state_q == ST_UP);
            assign leave_up[gi] = (state_q == ST_UP) && (state_d != ST_UP);
        end
    endgenerate

    logic [3:0] link_prev_q;
    logic       link_change_q;
    logic [7:0] drop_q, drop_d;
    logic [2:0] leave_cnt;
    logic [8:0] drop_sum;

    always_comb begin
        PairsUp   = '0;
        leave_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            PairsUp   = PairsUp + {2'b00, up_vec[i]};
            leave_cnt = leave_cnt + {2'b00, leave_up[i]};
        end
        drop_sum = {1'b0, drop_q} + {6'b000000, leave_cnt};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge Clock100Mhz) begin
        if (Reset) begin
            link_prev_q   <= '0;
            link_change_q <= 1'b0;
            drop_q        <= '0;
        end else begin
            link_prev_q   <= up_vec;
            link_change_q <= (up_vec != link_prev_q);
            drop_q        <= drop_d;
        end
    end

    assign LinkUp     = up_vec;
    assign AllUp      = &up_vec;
    assign LinkChange = link_change_q;
    assign DropCount  = drop_q;

endmodule

// File: tb/tb_pair_link_monitor.sv
// Directed bench for pair_link_monitor: pulse trains per pair with hand-computed link/drop expectations.
module tb_pair_link_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lines;
    logic [3:0] link_up;
    logic [2:0] pairs_up;
    logic       all_up;
    logic       link_change;
    logic [7:0] drop_count;

    int n_total = 0;
    int n_bad   = 0;
    int lc_cnt  = 0;
    int lc_mark;
    int exp_drop = 0;

    always #5 clk = ~clk;

    pair_link_monitor dut (
        .Clock100Mhz (clk),
        .Reset       (rst),
        .TIA_568B12  (lines[0]),
        .TIA_568B36  (lines[1]),
        .TIA_568B54  (lines[2]),
        .TIA_568B78  (lines[3]),
        .LinkUp      (link_up),
        .PairsUp     (pairs_up),
        .AllUp       (all_up),
        .LinkChange  (link_change),
        .DropCount   (drop_count)
    );

    always @(negedge clk) begin
        if (link_change === 1'b1)
            lc_cnt <= lc_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: value=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each pulse: raise for width ticks, then idle for the rest of the period.
    task automatic run_pulses(input logic [3:0] mask, input int n, input int period, input int width);
        for (int k = 0; k < n; k++) begin
            lines = lines | mask;
            repeat (width) tick();
            lines = lines & ~mask;
            repeat (period - width) tick();
        end
    endtask

    task automatic add_drops(input int k);
        exp_drop = (exp_drop + k > 255) ? 255 : exp_drop + k;
    endtask

    initial begin
        rst   = 1'b1;
        lines = 4'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_linkup", {28'd0, link_up}, 32'h0);
        check_eq("rst_pairsup", {29'd0, pairs_up}, 32'h0);
        check_eq("rst_allup", {31'd0, all_up}, 32'h0);
        check_eq("rst_linkchange", {31'd0, link_change}, 32'h0);
        check_eq("rst_dropcount", {24'd0, drop_count}, 32'h0);

        // Pair 0: entry edge + 2 valid edges is still ACQUIRE; exact latency on the 4th edge.
        run_pulses(4'h1, 3, 80, 4);
        check_eq("p0_acquire", {28'd0, link_up}, 32'h0);
        lines = lines | 4'h1;
        tick(); tick();
        check_eq("p0_latency_before", {28'd0, link_up}, 32'h0);
        tick();
        check_eq("p0_up", {28'd0, link_up}, 32'h1);
        check_eq("p0_pairsup", {29'd0, pairs_up}, 32'h1);
        check_eq("p0_allup", {31'd0, all_up}, 32'h0);
        check_eq("p0_lc_before", {31'd0, link_change}, 32'h0);
        tick();
        lines = lines & ~4'h1;
        check_eq("p0_lc_pulse", {31'd0, link_change}, 32'h1);
        tick();
        check_eq("p0_lc_after", {31'd0, link_change}, 32'h0);
        repeat (118) tick();
        check_eq("p0_pre_timeout", {28'd0, link_up}, 32'h1);
        tick();
        add_drops(1);
        check_eq("p0_timeout", {28'd0, link_up}, 32'h0);
        check_eq("p0_drop", {24'd0, drop_count}, exp_drop);

        // All pairs up, then stop: simultaneous drop of four.
        run_pulses(4'hF, 4, 80, 4);
        check_eq("all_up_vec", {28'd0, link_up}, 32'hF);
        check_eq("all_allup", {31'd0, all_up}, 32'h1);
        check_eq("all_pairsup", {29'd0, pairs_up}, 32'h4);
        lc_mark = lc_cnt;
        repeat (130) tick();
        add_drops(4);
        check_eq("all_down_vec", {28'd0, link_up}, 32'h0);
        check_eq("all_down_pairsup", {29'd0, pairs_up}, 32'h0);
        check_eq("all_drop", {24'd0, drop_count}, exp_drop);
        check_eq("all_lc_count", lc_cnt - lc_mark, 32'd1);

        // Pair 2: early edge (gap 30) drops it; the next edge only re-enters ACQUIRE.
        run_pulses(4'h4, 3, 80, 4);
        run_pulses(4'h4, 1, 31, 4);
        check_eq("p2_up", {28'd0, link_up}, 32'h4);
        run_pulses(4'h4, 1, 31, 4);
        add_drops(1);
        check_eq("p2_short_gap", {28'd0, link_up}, 32'h0);
        check_eq("p2_short_drop", {24'd0, drop_count}, exp_drop);
        run_pulses(4'h4, 3, 80, 4);
        check_eq("p2_reacquire", {28'd0, link_up}, 32'h0);
        run_pulses(4'h4, 1, 80, 4);
        check_eq("p2_relink", {28'd0, link_up}, 32'h4);
        repeat (60) tick();
        add_drops(1);
        check_eq("p2_timeout_drop", {24'd0, drop_count}, exp_drop);

        // Pair 1: width fault, then gap 120 accepted and gap 121 timing out.
        run_pulses(4'h2, 4, 80, 4);
        check_eq("p1_up", {28'd0, link_up}, 32'h2);
        run_pulses(4'h2, 1, 80, 12);
        add_drops(1);
        check_eq("p1_width_fault", {28'd0, link_up}, 32'h0);
        check_eq("p1_width_drop", {24'd0, drop_count}, exp_drop);
        run_pulses(4'h2, 4, 80, 4);
        run_pulses(4'h2, 1, 121, 4);
        run_pulses(4'h2, 1, 121, 4);
        check_eq("p1_gap_max_ok", {28'd0, link_up}, 32'h2);
        tick(); tick();
        check_eq("p1_pre_timeout", {28'd0, link_up}, 32'h2);
        tick();
        add_drops(1);
        check_eq("p1_gap_timeout", {28'd0, link_up}, 32'h0);
        check_eq("p1_timeout_drop", {24'd0, drop_count}, exp_drop);

        // Pair 3: gap 40 is accepted, gap 39 is rejected.
        run_pulses(4'h8, 3, 41, 4);
        run_pulses(4'h8, 1, 40, 4);
        check_eq("p3_min_gap_up", {28'd0, link_up}, 32'h8);
        run_pulses(4'h8, 1, 40, 4);
        add_drops(1);
        check_eq("p3_gap39_down", {28'd0, link_up}, 32'h0);
        check_eq("p3_gap39_drop", {24'd0, drop_count}, exp_drop);

        // Saturation: 70 rounds of four drops each.
        for (int it = 0; it < 70; it++) begin
            run_pulses(4'hF, 4, 41, 4);
            if (it == 0)
                check_eq("sat_round0_up", {28'd0, link_up}, 32'hF);
            repeat (125) tick();
            add_drops(4);
            if (it == 0 || it == 60)
                check_eq("sat_partial", {24'd0, drop_count}, exp_drop);
        end
        check_eq("sat_final", {24'd0, drop_count}, 32'd255);

        // Reset while all pairs are UP.
        run_pulses(4'hF, 4, 80, 4);
        check_eq("rst_pre_up", {28'd0, link_up}, 32'hF);
        rst = 1'b1;
        tick();
        check_eq("rst_mid_linkup", {28'd0, link_up}, 32'h0);
        check_eq("rst_mid_allup", {31'd0, all_up}, 32'h0);
        check_eq("rst_mid_drop", {24'd0, drop_count}, 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        check_eq("rst_post_drop", {24'd0, drop_count}, 32'h0);
        check_eq("rst_post_lc", {31'd0, link_change}, 32'h0);
        run_pulses(4'h1, 4, 80, 4);
        check_eq("rst_relink", {28'd0, link_up}, 32'h1);
        check_eq("rst_relink_pairsup", {29'd0, pairs_up}, 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pair_link_monitor.md
# pair_link_monitor

Per-pair link-integrity monitor sitting directly downstream of the post-LNA pair checkers. It consumes the four recovered pair lines (TIA_568B12, TIA_568B36, TIA_568B54, TIA_568B78) and qualifies periodic link pulses on each line. It reports per-pair link state, aggregate status, and a saturating drop counter to the system controller.

## Interface

Parameters:
- MinGap, 40: minimum accepted cycles between rising edges on a pair.
- MaxGap, 120: maximum accepted cycles between rising edges; exceeding it is a timeout.
- MaxWidth, 8: maximum high-time in cycles for a valid pulse.
- PulsesToUp, 3: consecutive in-window edges needed in ACQUIRE to declare link UP (range 1..15).

Ports:
- Clock100Mhz  input  1  sole clock, rising edge.
- Reset  input  1  synchronous, active-high.
- TIA_568B12  input  1  pair 0 line, asynchronous to Clock100Mhz.
- TIA_568B36  input  1  pair 1 line, asynchronous.
- TIA_568B54  input  1  pair 2 line, asynchronous.
- TIA_568B78  input  1  pair 3 line, asynchronous.
- LinkUp  output  4  per-pair UP flag; bit i = pair i.
- PairsUp  output  3  population count of LinkUp (0..4).
- AllUp  output  1  LinkUp == 4'b1111.
- LinkChange  output  1  one-cycle pulse whenever any LinkUp bit changed.
- DropCount  output  8  saturating count of UP->DOWN transitions.

## Operation

- Each input passes through a 2-flop synchronizer, then a previous-value register. Edge = sync2 & ~prev.
- Four identical per-pair channels. Each channel has:
  - a 2-bit state: DOWN, ACQUIRE, UP;
  - a gap counter, width clog2(MaxGap+2), cleared on any edge, incremented otherwise, saturating at MaxGap+1;
  - a high-width counter, cleared when sync2 is low, incremented while high, saturating at MaxWidth+1;
  - a 4-bit good-pulse counter.
- Gap check on an edge: valid when MinGap ≤ gap ≤ MaxGap, where gap is the gap counter value in the edge cycle.
- Transitions, in priority order per cycle:
  1. Width fault: high-width counter reaches MaxWidth+1 → DOWN, from any state.
  2. Timeout: in ACQUIRE or UP, gap counter == MaxGap with no edge this cycle → DOWN.
  3. Edge in DOWN → ACQUIRE, good counter = 0.
  4. Valid edge in ACQUIRE → good counter +1. When the new value equals PulsesToUp → UP.
  5. Valid edge in UP → stay UP.
  6. Invalid edge (gap < MinGap) in ACQUIRE or UP → DOWN.
- LinkUp[i] = (state_i == UP), driven from the registered state.
- PairsUp and AllUp are combinational from LinkUp.
- LinkChange is registered: it is high for one cycle after any LinkUp bit differs from its previous-cycle value.
- DropCount adds the number of pairs leaving UP in that cycle (0..4). The sum saturates at 255 and never wraps.

## Timing

- Reset values: all channels DOWN, all counters 0, synchronizer and prev registers 0. LinkUp=0, PairsUp=0, AllUp=0, LinkChange=0, DropCount=0.
- Reset asserted mid-operation overrides all transitions in that cycle. No drop is counted for pairs forced down by reset.
- Latency: an input first sampled high at edge N produces Edge in the cycle after edge N+1. The state update is visible after edge N+2. LinkChange follows after edge N+3.
- Timeout: with the last edge accepted at counter clear, LinkUp falls MaxGap+1 cycles after that clear.
- An edge landing exactly at gap == MaxGap is accepted. At MinGap−1 it is rejected.
- Simultaneous drops on k pairs in one cycle add k to DropCount.
- Pairs are fully independent. There is no cross-pair arbitration.

## Test plan

- Reset, then pulses of width 4 on pair 0 with period 80 → LinkUp=0001 after the 4th edge (1 entry + 3 valid); PairsUp=1; LinkChange pulses once.
- All four pairs pulsed at period 80 → LinkUp=1111, AllUp=1, PairsUp=4. Stop all pulses → all drop in the same cycle; DropCount=4; a single LinkChange pulse.
- Pair 2 UP, then one edge at gap 30 → pair 2 DOWN; DropCount+1. The next edge → ACQUIRE.
- Pair 1 UP, then hold the line high for 12 cycles → DOWN via width fault. Gap of exactly 120 is accepted; gap of 121 times out.
- Repeatedly bring all pairs up and drop them 70 times (280 drops) → DropCount stays at 255.
- Assert Reset while pairs are UP → all outputs 0 the next cycle; DropCount unchanged by the forced drop; relink succeeds normally afterwards.
